// File: rtl/uart_bram_writer.sv
// Writes UART receive bytes in order into NUM_STRIPS strip BRAMs and flags strip/frame completion.
// Optional running byte checksum output is enabled by defining UART_BRAM_WRITER_CHECKSUM_EN.
module uart_bram_writer #(
    parameter int NUM_STRIPS       = 8,
    parameter int STRIP_DEPTH      = 6216,
    parameter int LAST_STRIP_DEPTH = 5772,
    parameter int ADDR_W           = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic [NUM_STRIPS-1:0] bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [7:0]            bram_din,
    output logic [2:0]            strip_idx,
    output logic [NUM_STRIPS-1:0] strip_write_complete,
    output logic                  write_complete,
    output logic                  overrun
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_WRITE = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [ADDR_W-1:0] STRIP_LAST = ADDR_W'(STRIP_DEPTH - 1);
    localparam logic [ADDR_W-1:0] FINAL_LAST = ADDR_W'(LAST_STRIP_DEPTH - 1);
    localparam logic [2:0]        LAST_IDX   = 3'(NUM_STRIPS - 1);

    state_e                  state_q, state_d;
    logic [NUM_STRIPS-1:0]   we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [7:0]              din_q, din_d;
    logic [ADDR_W-1:0]       cnt_q, cnt_d;
    logic [2:0]              idx_q, idx_d;
    logic [NUM_STRIPS-1:0]   swc_q, swc_d;
    logic                    wc_q, wc_d;
    logic                    ovr_q, ovr_d;
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
    logic [15:0]             cksum_q, cksum_d;
`endif

    logic [NUM_STRIPS-1:0]   onehot_s;
    logic                    last_strip_s;
    logic                    last_byte_s;

    assign onehot_s     = {{(NUM_STRIPS-1){1'b0}}, 1'b1} << idx_q;
    assign last_strip_s = (idx_q == LAST_IDX);
    // The final strip is shorter, so its terminal address differs.
    assign last_byte_s  = last_strip_s ? (cnt_q == FINAL_LAST) : (cnt_q == STRIP_LAST);

    // State and datapath registers with asynchronous abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= '0;
            addr_q  <= '0;
            din_q   <= 8'd0;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            swc_q   <= '0;
            wc_q    <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
            cksum_q <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            swc_q   <= swc_d;
            wc_q    <= wc_d;
            ovr_q   <= ovr_d;
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)        state_d = ST_WAIT;  else state_d = ST_IDLE;
            ST_WAIT:  if (rx_valid)     state_d = ST_WRITE; else state_d = ST_WAIT;
            ST_WRITE: if (last_byte_s)  state_d = ST_NEXT;  else state_d = ST_WAIT;
            ST_NEXT:  if (last_strip_s) state_d = ST_DONE;  else state_d = ST_WAIT;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the output and counter registers.
    always_comb begin
        we_d    = '0;
        addr_d  = addr_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        swc_d   = swc_q;
        wc_d    = wc_q;
        ovr_d   = ovr_q;
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
        cksum_d = cksum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    swc_d   = '0;
                    wc_d    = 1'b0;
                    ovr_d   = 1'b0;
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
                    cksum_d = 16'd0;
`endif
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT: begin
                if (rx_valid) begin
                    we_d   = onehot_s;
                    addr_d = cnt_q;
                    din_d  = rx_data;
                end else begin
                    we_d = '0;
                end
            end
            ST_WRITE: begin
                // A byte arriving while busy is dropped and only flagged.
                ovr_d = ovr_q | rx_valid;
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
                cksum_d = cksum_q + {8'd0, din_q};
`endif
                if (last_byte_s) begin
                    swc_d = swc_q | onehot_s;
                end else begin
                    cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_NEXT: begin
                ovr_d = ovr_q | rx_valid;
                cnt_d = '0;
                if (last_strip_s) begin
                    wc_d = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_DONE: begin
                wc_d = 1'b1;
            end
            default: begin
                we_d = '0;
            end
        endcase
    end

    assign bram_we              = we_q;
    assign bram_addr            = addr_q;
    assign bram_din             = din_q;
    assign strip_idx            = idx_q;
    assign strip_write_complete = swc_q;
    assign write_complete       = wc_q;
    assign overrun              = ovr_q;
`ifdef UART_BRAM_WRITER_CHECKSUM_EN
    assign checksum             = cksum_q;
`endif

endmodule
